rock_ctrl: RTL and testbench
============================

ROCK_CTRL -- requirements
Module: rock_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4194304, meaning clk cycles per control tick (>=2).
REQ-002 The block SHALL have parameter DEB_TICKS, default 3, meaning consecutive equal tick samples needed to change debounced stress.
REQ-003 The block SHALL have parameter STROKE_TICKS, default 4, meaning ticks spent in each PUSH and each PULL half-stroke.
REQ-004 The block SHALL have parameter CALM_TICKS, default 16, meaning consecutive calm ticks before rocking stops.
REQ-005 The block SHALL have parameter MAX_STROKES, default 64, meaning strokes per session before FAULT (<2^CNT_W).
REQ-006 The block SHALL have parameter CNT_W, default 8, meaning stroke counter width.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 The block SHALL have port enable, input, 1 bit, run enable; low forces IDLE.
REQ-010 The block SHALL have port stress, input, 1 bit, asynchronous baby-stress sensor.
REQ-011 The block SHALL have port fplus, output, 1 bit, extend-cylinder drive.
REQ-012 The block SHALL have port fmin, output, 1 bit, retract-cylinder drive.
REQ-013 The block SHALL have port amin, output, 1 bit, cradle-release valve, high while rocking.
REQ-014 The block SHALL have port busy, output, 1 bit, high in PUSH or PULL.
REQ-015 The block SHALL have port fault, output, 1 bit, high in FAULT.
REQ-016 The block SHALL have port strokes, output, CNT_W bits, strokes started this session.

Function
REQ-017 The block SHALL synchronise stress through two flops before any use.
REQ-018 The tick counter SHALL count 0..TICK_DIV-1 while enable=1, assert a one-cycle internal tick when at TICK_DIV-1, then wrap to 0; enable=0 holds it at 0 with no tick.
REQ-019 Debounced stress SHALL change only on a tick where the synchronised value has differed from it on DEB_TICKS consecutive ticks; any agreeing sample clears the run count.
REQ-020 The calm counter SHALL increment (saturating at CALM_TICKS) on each tick with debounced stress=0 and clear on each tick with debounced stress=1.
REQ-021 FSM states SHALL be IDLE, PUSH, PULL, FAULT; transitions occur only on tick unless stated.
REQ-022 IDLE: tick with debounced stress=1 SHALL go to PUSH, increment strokes, clear calm counter.
REQ-023 PUSH: after STROKE_TICKS ticks SHALL go to PULL.
REQ-024 PULL end (STROKE_TICKS ticks): calm counter=CALM_TICKS -> IDLE and strokes cleared; else strokes=MAX_STROKES -> FAULT; else -> PUSH with strokes incremented.
REQ-025 FAULT SHALL be left only by reset or enable=0 (-> IDLE, strokes cleared).
REQ-026 Outputs SHALL be registered: fplus=PUSH, fmin=PULL, amin=PUSH|PULL, busy=PUSH|PULL, fault=FAULT, each valid the cycle after the state change.
REQ-027 fplus and fmin SHALL never be high in the same cycle.
REQ-028 enable=0 in any state SHALL, on the next clk edge, force IDLE, all outputs 0, and clear tick, debounce, calm, stroke counters.
REQ-029 strokes SHALL never wrap; it saturates at MAX_STROKES.

Reset
REQ-030 reset=1 SHALL on the next clk edge set state IDLE, fplus=fmin=amin=busy=fault=0, strokes=0, debounced stress=0, all counters 0; reset SHALL override enable.
REQ-031 Reset asserted mid-stroke SHALL drop fplus/fmin on the next edge with no further pulse.

Verification (TICK_DIV=4, DEB_TICKS=2, STROKE_TICKS=2, CALM_TICKS=3, MAX_STROKES=3, enable=1)
REQ-032 Reset then idle, stress=0 -> all outputs 0, internal tick every 4 clk, strokes=0.
REQ-033 stress held 1 -> debounced on 2nd tick, PUSH on next tick; fplus=amin=1 for 8 clk, then fmin=1 for 8 clk, strokes=1 then 2.
REQ-034 stress pulse covering one tick only -> no PUSH, outputs remain 0.
REQ-035 stress drops during stroke 1 -> calm reaches 3, at PULL end IDLE, amin=0, strokes=0.
REQ-036 stress held 1 continuously -> after 3rd PULL fault=1, fplus=fmin=amin=0, strokes=3; enable pulsed 0 -> IDLE, fault=0.
REQ-037 enable=0 or reset mid-PUSH -> next clk fplus=amin=busy=0, strokes=0.

Source files
------------

// File: rtl/rock_ctrl.sv
// rock_ctrl: cradle-rocking controller. Debounces an asynchronous stress
// sensor on a slow control tick and drives a push/pull cylinder pair while
// the baby is stressed. Rocking stops after a calm period, or faults after
// too many strokes in one session.
module rock_ctrl #(
   parameter int TICK_DIV     = 4194304,
   parameter int DEB_TICKS    = 3,
   parameter int STROKE_TICKS = 4,
   parameter int CALM_TICKS   = 16,
   parameter int MAX_STROKES  = 64,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             stress,
   output logic             fplus,
   output logic             fmin,
   output logic             amin,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] strokes
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int DEB_W  = $clog2(DEB_TICKS + 1);
   localparam int CALM_W = $clog2(CALM_TICKS + 1);
   localparam int PH_W   = $clog2(STROKE_TICKS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PUSH  = 2'd1,
      ST_PULL  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Stroke count increment that never passes MAX_STROKES.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_W'(MAX_STROKES)) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   logic              sync1_q, sync1_d, sync2_q, sync2_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick_s;
   logic              deb_q, deb_d;
   logic [DEB_W-1:0]  run_q, run_d;
   logic [CALM_W-1:0] calm_q, calm_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  strokes_q, strokes_d;
   logic              fplus_q, fplus_d, fmin_q, fmin_d, amin_q, amin_d;
   logic              busy_q, busy_d, fault_q, fault_d;

   // Next-state logic: sync chain, tick divider, debounce, calm timer, FSM, outputs.
   always_comb begin
      sync1_d    = stress;
      sync2_d    = sync1_q;
      tick_cnt_d = tick_cnt_q;
      tick_s     = 1'b0;
      deb_d      = deb_q;
      run_d      = run_q;
      calm_d     = calm_q;
      ph_d       = ph_q;
      state_d    = state_q;
      strokes_d  = strokes_q;

      if (!enable) begin
         tick_cnt_d = {TICK_W{1'b0}};
         deb_d      = 1'b0;
         run_d      = {DEB_W{1'b0}};
         calm_d     = {CALM_W{1'b0}};
         ph_d       = {PH_W{1'b0}};
         state_d    = ST_IDLE;
         strokes_d  = {CNT_W{1'b0}};
      end else begin
         if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
            tick_s     = 1'b1;
            tick_cnt_d = {TICK_W{1'b0}};
         end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
         end

         if (tick_s) begin
            // Debounce: flip only after DEB_TICKS disagreeing samples in a row.
            if (sync2_q != deb_q) begin
               if (run_q == DEB_W'(DEB_TICKS - 1)) begin
                  deb_d = sync2_q;
                  run_d = {DEB_W{1'b0}};
               end else begin
                  run_d = run_q + DEB_W'(1);
               end
            end else begin
               run_d = {DEB_W{1'b0}};
            end

            // Calm timer tracks the debounced value held before this tick.
            if (deb_q) begin
               calm_d = {CALM_W{1'b0}};
            end else if (calm_q != CALM_W'(CALM_TICKS)) begin
               calm_d = calm_q + CALM_W'(1);
            end else begin
               calm_d = calm_q;
            end

            case (state_q)
               ST_IDLE: begin
                  if (deb_q) begin
                     state_d   = ST_PUSH;
                     ph_d      = {PH_W{1'b0}};
                     strokes_d = sat_inc(strokes_q);
                     calm_d    = {CALM_W{1'b0}};
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               ST_PUSH: begin
                  if (ph_q == PH_W'(STROKE_TICKS - 1)) begin
                     state_d = ST_PULL;
                     ph_d    = {PH_W{1'b0}};
                  end else begin
                     ph_d = ph_q + PH_W'(1);
                  end
               end
               ST_PULL: begin
                  if (ph_q == PH_W'(STROKE_TICKS - 1)) begin
                     ph_d = {PH_W{1'b0}};
                     if (calm_q == CALM_W'(CALM_TICKS)) begin
                        state_d   = ST_IDLE;
                        strokes_d = {CNT_W{1'b0}};
                     end else if (strokes_q == CNT_W'(MAX_STROKES)) begin
                        state_d = ST_FAULT;
                     end else begin
                        state_d   = ST_PUSH;
                        strokes_d = sat_inc(strokes_q);
                     end
                  end else begin
                     ph_d = ph_q + PH_W'(1);
                  end
               end
               ST_FAULT: begin
                  state_d = ST_FAULT;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end else begin
            state_d = state_q;
         end
      end

      // Outputs decode the next state so they change on the same edge as the state.
      fplus_d = (state_d == ST_PUSH);
      fmin_d  = (state_d == ST_PULL);
      amin_d  = (state_d == ST_PUSH) || (state_d == ST_PULL);
      busy_d  = (state_d == ST_PUSH) || (state_d == ST_PULL);
      fault_d = (state_d == ST_FAULT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         tick_cnt_q <= {TICK_W{1'b0}};
         deb_q      <= 1'b0;
         run_q      <= {DEB_W{1'b0}};
         calm_q     <= {CALM_W{1'b0}};
         ph_q       <= {PH_W{1'b0}};
         state_q    <= ST_IDLE;
         strokes_q  <= {CNT_W{1'b0}};
         fplus_q    <= 1'b0;
         fmin_q     <= 1'b0;
         amin_q     <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         tick_cnt_q <= tick_cnt_d;
         deb_q      <= deb_d;
         run_q      <= run_d;
         calm_q     <= calm_d;
         ph_q       <= ph_d;
         state_q    <= state_d;
         strokes_q  <= strokes_d;
         fplus_q    <= fplus_d;
         fmin_q     <= fmin_d;
         amin_q     <= amin_d;
         busy_q     <= busy_d;
         fault_q    <= fault_d;
      end
   end

   assign fplus   = fplus_q;
   assign fmin    = fmin_q;
   assign amin    = amin_q;
   assign busy    = busy_q;
   assign fault   = fault_q;
   assign strokes = strokes_q;

endmodule

// File: tb/tb_rock_ctrl.sv
// tb_rock_ctrl: randomized and directed stimulus for rock_ctrl, compared every
// cycle against a tick-level behavioural model of the rocking session.
module tb_rock_ctrl;

   localparam int TD    = 4;
   localparam int DEB   = 2;
   localparam int ST    = 2;
   localparam int CALM  = 3;
   localparam int MAXS  = 3;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset, enable, stress;
   logic             fplus, fmin, amin, busy, fault;
   logic [CNT_W-1:0] strokes;

   int n_vec  = 0;
   int n_fail = 0;

   // Model: sync pipe, tick phase, debounce, calm, and the session as
   // mode (0 idle, 1 rocking, 3 fault) plus position within the stroke.
   int m_s1, m_s2, m_tc, m_deb, m_run, m_calm, m_mode, m_pos, m_str;

   rock_ctrl #(
      .TICK_DIV(TD), .DEB_TICKS(DEB), .STROKE_TICKS(ST),
      .CALM_TICKS(CALM), .MAX_STROKES(MAXS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .stress(stress),
      .fplus(fplus), .fmin(fmin), .amin(amin), .busy(busy),
      .fault(fault), .strokes(strokes)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      int  os2, od, oc;
      bit  tk;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_tc = 0; m_deb = 0; m_run = 0;
         m_calm = 0; m_mode = 0; m_pos = 0; m_str = 0;
         return;
      end
      os2  = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(stress);
      if (!enable) begin
         m_tc = 0; m_deb = 0; m_run = 0; m_calm = 0;
         m_mode = 0; m_pos = 0; m_str = 0;
         return;
      end
      tk   = (m_tc == TD - 1);
      m_tc = tk ? 0 : m_tc + 1;
      if (!tk) return;
      od = m_deb;
      oc = m_calm;
      if (os2 != od) begin
         m_run = m_run + 1;
         if (m_run == DEB) begin
            m_deb = os2;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      m_calm = od ? 0 : ((oc < CALM) ? oc + 1 : CALM);
      if (m_mode == 0) begin
         if (od != 0) begin
            m_mode = 1; m_pos = 0; m_calm = 0;
            m_str  = (m_str < MAXS) ? m_str + 1 : MAXS;
         end
      end else if (m_mode == 1) begin
         m_pos = m_pos + 1;
         if (m_pos == 2 * ST) begin
            m_pos = 0;
            if (oc == CALM) begin
               m_mode = 0; m_str = 0;
            end else if (m_str == MAXS) begin
               m_mode = 3;
            end else begin
               m_str = m_str + 1;
            end
         end
      end
   endtask

   // One clock: drive at negedge, advance model at posedge, compare 1 unit later.
   task automatic cyc(input logic r, input logic e, input logic s);
      logic xp, xm, xr, xf;
      @(negedge clk);
      reset = r; enable = e; stress = s;
      @(posedge clk);
      model_step();
      #1;
      xr = (m_mode == 1);
      xp = xr && (m_pos < ST);
      xm = xr && (m_pos >= ST);
      xf = (m_mode == 3);
      check_val("fplus",   32'(fplus),   32'(xp));
      check_val("fmin",    32'(fmin),    32'(xm));
      check_val("amin",    32'(amin),    32'(xr));
      check_val("busy",    32'(busy),    32'(xr));
      check_val("fault",   32'(fault),   32'(xf));
      check_val("strokes", 32'(strokes), 32'(m_str));
      check_val("excl",    32'(fplus & fmin), 32'd0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; stress = 1'b0;
      // Reset then quiet idle.
      for (int i = 0; i < 3; i++)  cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0);
      // Stress held, then dropped during the first stroke so calm ends the session.
      for (int i = 0; i < 30; i++)  cyc(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 120; i++) cyc(1'b0, 1'b1, 1'b0);
      // Short pulse spanning at most one tick sample: no rocking.
      for (int i = 0; i < 4; i++)  cyc(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0);
      // Continuous stress runs out the stroke budget into FAULT; enable clears it.
      for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++)   cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++)  cyc(1'b0, 1'b1, 1'b0);
      // Reset in the middle of a push.
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b1, 1'b1);
         if (m_mode == 1 && m_pos < ST) break;
      end
      cyc(1'b1, 1'b1, 1'b1);
      // Enable drop in the middle of a push.
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b1, 1'b1);
         if (m_mode == 1 && m_pos < ST) break;
      end
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
      // Random sessions: slow stress toggling with rare enable drops and resets.
      begin
         logic s = 1'b0;
         for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) s = ~s;
            cyc(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, s);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
